fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the single-issue ARM CPU. Holds the 64-bit program counter, drives it as the byte address into the instruction memory, and registers the returned 32-bit word, together with its PC, into an IF/ID output register. Downstream decode consumes that register through a valid/ready handshake. Decode or execute can redirect the stage with a taken branch. The stage halts permanently on an out-of-range or misaligned PC.

## Interface
- `RESET_PC`, default 0: PC loaded on reset; byte address, must be 4-aligned.
- `IMEM_SIZE`, default 256: instruction memory size in bytes. A fetch at `pc` is legal only if `pc + 4 <= IMEM_SIZE`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_address` out 64: current PC, driven combinationally from the PC register to the instruction memory address input.
- `imem_data` in 32: combinational instruction word returned for `imem_address` (little-endian, assembled by memory).
- `branch_taken` in 1: redirect request, sampled each edge.
- `branch_target` in 64: redirect byte address, valid when `branch_taken`.
- `decode_ready` in 1: decode accepts `out_*` this cycle.
- `out_valid` out 1: IF/ID register holds a live instruction.
- `out_instruction` out 32: registered instruction word.
- `out_pc` out 64: registered address of `out_instruction`.
- `halted` out 1: stage is in HALT.
- `fetch_count` out 32: number of completed handshakes (`out_valid && decode_ready` at an edge); wraps 0xFFFFFFFF→0.

## Operation
- **State machine:** RUN and HALT.
  - Reset → RUN.
  - HALT is sticky until `reset`.
- **Legal PC:** `pc[1:0] == 0` and `pc + 4 <= IMEM_SIZE`. The addition is evaluated 65 bits wide, so it cannot wrap.
- **Advance condition:** `adv = !out_valid || decode_ready`.
- **RUN, per edge, in priority order:**
  1. `branch_taken`: `out_valid <= 0` (flush); `pc <= branch_target`. The legality of the target is checked on a later cycle, when it is fetched. Branch beats stall.
  2. `!adv` (stall): `pc` and all `out_*` hold.
  3. `adv` and `pc` legal: `out_instruction <= imem_data`, `out_pc <= pc`, `out_valid <= 1`, `pc <= pc + 4` (mod 2^64).
  4. `adv` and `pc` illegal: `out_valid <= 0`; go to HALT; `pc` holds.
- **HALT:**
  - No new fetch.
  - If `out_valid && decode_ready`, `out_valid <= 0`; otherwise `out_*` hold.
  - `branch_taken` clears `out_valid` but does not change `pc` or state.
  - `imem_address` keeps showing the offending PC.
- **`fetch_count`:** increments on every edge where `out_valid && decode_ready` and `reset` is low. This includes the edge a branch flushes the register, because that handshake completed.
- **Reset values:**
  - `pc` = `RESET_PC`, so `imem_address` = `RESET_PC`.
  - `out_valid` = 0, `out_instruction` = 0, `out_pc` = 0.
  - `halted` = 0, `fetch_count` = 0.
- **Reset mid-operation:** discards any pending instruction, branch or halt on that edge. It has priority over everything.

## Timing
- **Fetch latency:** word at `pc` appears on `out_*` with `out_valid = 1` one edge after `pc` is presented.
- **After reset:** first `out_valid = 1` on the first edge after `reset` deasserts, with `out_pc = RESET_PC`.
- **Throughput:** one instruction per cycle while `decode_ready` stays high.
- **Branch sampled at edge N:**
  - N+1: `out_valid = 0`, `imem_address = target`.
  - N+2: target instruction valid.
  - Exactly one bubble.
- **Stall:** `out_*` stable for as long as `out_valid && !decode_ready`. Data must not change while valid and not accepted.
- **`halted`:** rises on the edge that detects the illegal PC. The last legal instruction may still be valid in that same cycle, and drains normally.
- **Combinational path:** only `pc` → `imem_address`. Every `out_*` comes from a register.

## Test plan
- **Sequential fetch:** memory preloaded with 0x8b1f03e5, 0xf84000a4, 0x8b040086, 0xf80010a6 at 0, 4, 8, 12; `decode_ready = 1`; release reset.
  - Required: `out_pc` = 0, 4, 8, 12 on consecutive cycles carrying those words.
  - Required: `fetch_count` = 4 after the fourth accept.
- **Stall:** drop `decode_ready` for 3 cycles while `out_pc = 4`.
  - Required: `out_instruction` holds 0xf84000a4, `imem_address` holds 8, `fetch_count` frozen.
  - Required: on release, next `out_pc = 8`.
- **Branch:** `branch_taken = 1`, `branch_target = 0` while `out_pc = 8`, with `decode_ready = 0` that cycle.
  - Required: next cycle `out_valid = 0`; following cycle `out_pc = 0`, `out_instruction = 0x8b1f03e5`.
- **End of memory:** `IMEM_SIZE = 16`, run sequentially.
  - Required: after `out_pc = 12` is accepted, `out_valid` stays 0, `halted = 1`, `imem_address = 16`.
  - Required: later `branch_taken` to 0 leaves `halted = 1`.
- **Misaligned branch:** `branch_target = 6`.
  - Required: one bubble, then `halted = 1`, `out_valid = 0`, `imem_address = 6`.
- **Reset mid-stall:** assert `reset` while `out_valid = 1` and `decode_ready = 0`.
  - Required: next cycle `out_valid = 0`, `fetch_count = 0`, `imem_address = RESET_PC`, `halted = 0`.

Source files
------------

// File: rtl/fetch_if.sv
// Bundle between the fetch stage, its instruction memory and the decode stage.
// master = fetch stage side, slave = memory/decode environment.
interface fetch_if;
  logic [63:0] imem_address;
  logic [31:0] imem_data;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        decode_ready;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [63:0] out_pc;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    output imem_address,
    input  imem_data,
    input  branch_taken,
    input  branch_target,
    input  decode_ready,
    output out_valid,
    output out_instruction,
    output out_pc,
    output halted,
    output fetch_count
  );

  modport slave (
    input  imem_address,
    output imem_data,
    output branch_taken,
    output branch_target,
    output decode_ready,
    input  out_valid,
    input  out_instruction,
    input  out_pc,
    input  halted,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID output register with valid/ready
// handshake, branch redirect and a sticky halt on an illegal PC.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter logic [63:0] IMEM_SIZE = 64'd256
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e      state_q,           state_d;
  logic [63:0] pc_q,              pc_d;
  logic        out_valid_q,       out_valid_d;
  logic [31:0] out_instruction_q, out_instruction_d;
  logic [63:0] out_pc_q,          out_pc_d;
  logic [31:0] fetch_count_q,     fetch_count_d;

  logic        adv;
  logic        handshake;
  logic        pc_legal;
  logic [64:0] pc_end;

  // End address computed one bit wider so pc near 2^64 cannot wrap to legal.
  assign pc_end    = {1'b0, pc_q} + 65'd4;
  assign pc_legal  = (pc_q[1:0] == 2'b00) && (pc_end <= {1'b0, IMEM_SIZE});
  assign handshake = out_valid_q && bus.decode_ready;
  assign adv       = !out_valid_q || bus.decode_ready;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d           = state_q;
    pc_d              = pc_q;
    out_valid_d       = out_valid_q;
    out_instruction_d = out_instruction_q;
    out_pc_d          = out_pc_q;
    fetch_count_d     = fetch_count_q;

    if (handshake) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    unique case (state_q)
      ST_RUN: begin
        if (bus.branch_taken) begin
          out_valid_d = 1'b0;
          pc_d        = bus.branch_target;
        end else if (!adv) begin
          // stall: everything holds
        end else if (pc_legal) begin
          out_instruction_d = bus.imem_data;
          out_pc_d          = pc_q;
          out_valid_d       = 1'b1;
          pc_d              = pc_q + 64'd4;
        end else begin
          out_valid_d = 1'b0;
          state_d     = ST_HALT;
        end
      end
      ST_HALT: begin
        // pc stays on the offending address; only the output register drains.
        if (bus.branch_taken || handshake) begin
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state_q           <= ST_RUN;
      pc_q              <= RESET_PC;
      out_valid_q       <= 1'b0;
      out_instruction_q <= 32'd0;
      out_pc_q          <= 64'd0;
      fetch_count_q     <= 32'd0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      out_valid_q       <= out_valid_d;
      out_instruction_q <= out_instruction_d;
      out_pc_q          <= out_pc_d;
      fetch_count_q     <= fetch_count_d;
    end
  end

  assign bus.imem_address    = pc_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_instruction = out_instruction_q;
  assign bus.out_pc          = out_pc_q;
  assign bus.halted          = (state_q == ST_HALT);
  assign bus.fetch_count     = fetch_count_q;

endmodule
